// File: rtl/alu_seq_if.sv
// alu_seq_if: decoder handshake plus accumulator/ALU datapath strobes for the ALU sequencer.
interface alu_seq_if;
  logic       instr_valid;
  logic [7:0] opcode;
  logic       instr_ready;
  logic       operand_valid;
  logic       abort;
  logic       a_to_act;
  logic       reg_src_en;
  logic [2:0] reg_src;
  logic       operand_req;
  logic       operand_src;
  logic       write_dbus_to_alu_tmp;
  logic [2:0] alu_fn;
  logic       alu_to_a;
  logic       flags_we;
  logic       done;
  logic       illegal;
  modport master (
    output instr_valid, opcode, operand_valid, abort,
    input  instr_ready, a_to_act, reg_src_en, reg_src, operand_req, operand_src,
           write_dbus_to_alu_tmp, alu_fn, alu_to_a, flags_we, done, illegal
  );
  modport slave (
    input  instr_valid, opcode, operand_valid, abort,
    output instr_ready, a_to_act, reg_src_en, reg_src, operand_req, operand_src,
           write_dbus_to_alu_tmp, alu_fn, alu_to_a, flags_we, done, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequences 8085 ALU-group instructions into accumulator/ALU datapath strobes.
module alu_seq (
  input logic     phi2,
  input logic     rst,
  alu_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD_A, TMP_REG, TMP_MEM, EXEC, WB} state_t;
  state_t     state_q, state_d;
  logic [2:0] fff_q, fff_d, sss_q, sss_d;
  logic       imm_q, imm_d, illegal_q, illegal_d;
  logic       legal;
  // 10xxxxxx is register/memory form; 11xxx110 is immediate form
  assign legal = bus.opcode[7] & (~bus.opcode[6] | (bus.opcode[2:0] == 3'b110));
  always_comb begin
    state_d   = state_q;
    fff_d     = fff_q;
    sss_d     = sss_q;
    imm_d     = imm_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: if (bus.instr_valid) begin
        fff_d     = bus.opcode[5:3];
        sss_d     = bus.opcode[2:0];
        imm_d     = bus.opcode[6];
        state_d   = legal ? LOAD_A : IDLE;
        illegal_d = ~legal;
      end
      LOAD_A:  state_d = (sss_q == 3'b110) ? TMP_MEM : TMP_REG;
      TMP_REG: state_d = EXEC;
      TMP_MEM: state_d = bus.operand_valid ? EXEC : TMP_MEM;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) state_d = IDLE;
  end
  always_ff @(posedge phi2 or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      fff_q     <= 3'b000;
      sss_q     <= 3'b000;
      imm_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fff_q     <= fff_d;
      sss_q     <= sss_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
    end
  end
  // strobes decode straight from state so async reset clears them at once
  assign bus.instr_ready           = state_q == IDLE;
  assign bus.a_to_act              = state_q == LOAD_A;
  assign bus.reg_src_en            = state_q == TMP_REG;
  assign bus.reg_src               = (state_q == TMP_REG) ? sss_q : 3'b000;
  assign bus.operand_req           = state_q == TMP_MEM;
  assign bus.operand_src           = (state_q == TMP_MEM) & imm_q;
  assign bus.write_dbus_to_alu_tmp = (state_q == TMP_REG) | ((state_q == TMP_MEM) & bus.operand_valid);
  assign bus.alu_fn                = (state_q == IDLE) ? 3'b000 : fff_q;
  assign bus.alu_to_a              = (state_q == WB) & (fff_q != 3'b111);
  assign bus.flags_we              = state_q == WB;
  assign bus.done                  = state_q == WB;
  assign bus.illegal               = illegal_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Control sequencer for the 8085 ALU group instructions: ADD/ADC/SUB/SBB/ANA/XRA/ORA/CMP in register, memory (M) and immediate forms. Accepts a decoded opcode from the instruction register via valid/ready and drives the accumulator-datapath strobes that move operands into ACT and TMP, hold the ALU function, and write the result and flags back. The block sits between the instruction decoder and the accumulator/ALU datapath. It is the initiator side of that datapath's strobe interface.

## Interface
- No parameters.
- phi2  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_valid  in  1  opcode presented.
- opcode  in  8  instruction byte; sampled only on accept.
- instr_ready  out  1  sequencer idle and able to accept.
- operand_valid  in  1  memory/immediate byte is on the data bus this cycle.
- abort  in  1  synchronous flush; current instruction is dropped.
- a_to_act  out  1  copy accumulator into ACT.
- reg_src_en  out  1  register file drives register reg_src onto the data bus.
- reg_src  out  3  register index (sss field).
- operand_req  out  1  request a memory/immediate byte.
- operand_src  out  1  0 = memory via HL, 1 = immediate via PC; valid while operand_req=1.
- write_dbus_to_alu_tmp  out  1  latch data bus into TMP.
- alu_fn  out  3  ALU function (fff field), held for the whole instruction.
- alu_to_a  out  1  write ALU result to accumulator.
- flags_we  out  1  update flag register from ALU.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse: accepted opcode is not an ALU group instruction.

## Operation
- Decode of opcode: fff = opcode[5:3] (000 ADD, 001 ADC, 010 SUB, 011 SBB, 100 ANA, 101 XRA, 110 ORA, 111 CMP); sss = opcode[2:0].
- Register form: opcode[7:6]=10, sss≠110. Memory form: opcode[7:6]=10, sss=110. Immediate form: opcode[7:6]=11, sss=110. Every other opcode is illegal.
- States: IDLE, LOAD_A, TMP_REG, TMP_MEM, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid, latch fff/sss/form. Legal opcode → LOAD_A. Illegal opcode → stay IDLE and pulse illegal in the following cycle.
- LOAD_A: a_to_act=1. Next state: TMP_REG for register form, TMP_MEM for memory/immediate.
- TMP_REG: reg_src_en=1, reg_src=sss, write_dbus_to_alu_tmp=1. Next state: EXEC.
- TMP_MEM: operand_req=1 and operand_src set (memory=0, immediate=1). write_dbus_to_alu_tmp equals operand_valid combinationally. Stay in TMP_MEM until operand_valid=1, then EXEC. Wait is unbounded.
- EXEC: no strobes; ALU settles. Next state: WB.
- WB: flags_we=1 and done=1. alu_to_a=1 unless fff=111 (CMP updates flags only). Next state: IDLE.
- alu_fn holds the latched fff from LOAD_A through WB and is 000 in IDLE.
- abort: in any non-IDLE state, the next state is IDLE. No further strobes and no done. If abort is asserted in WB, the WB strobes still occur that cycle, because the transition to IDLE is already occurring.
- abort in IDLE is ignored; an accept in the same cycle takes priority.
- All strobe outputs are mutually consistent: at most one of a_to_act, write_dbus_to_alu_tmp, alu_to_a is high per cycle.

## Timing
- Reset (rst=0, asynchronous): state IDLE. Outputs instr_ready=1, alu_fn=000, reg_src=000, operand_src=0. All other outputs 0.
- Reset mid-instruction: outputs take the reset values immediately, without waiting for a clock edge. No done pulse.
- Register form, accept at edge E0:
  - LOAD_A after E0.
  - TMP_REG after E1.
  - EXEC after E2.
  - WB after E3.
  - IDLE after E4.
  - Latency from accept to done: 4 cycles. instr_ready returns after E4. Earliest next accept: E5.
- Memory/immediate form: 4 cycles + N, where N is the number of cycles operand_valid stays low in TMP_MEM. With operand_valid already high on the first TMP_MEM cycle, N=0.
- Illegal opcode: illegal pulses for the cycle after accept. instr_ready stays 1.
- operand_valid outside TMP_MEM is ignored.

## Test plan
- Reset: hold rst=0, then release → instr_ready=1, all strobes 0, alu_fn=000. Assert rst=0 during TMP_REG → strobes drop without a clock edge.
- ADD B (0x80): a_to_act for 1 cycle, then reg_src_en=1 with reg_src=000 and write_dbus_to_alu_tmp=1, then EXEC, then alu_to_a=flags_we=done=1 with alu_fn=000, 4 cycles after accept.
- CMP M (0xBE), operand_valid delayed 3 cycles: operand_req=1 with operand_src=0 for 4 cycles, TMP latch on the 4th. In WB, alu_to_a=0 and flags_we=1. alu_fn=111 throughout.
- XRI (0xEE), operand_valid already high: operand_src=1, done 4 cycles after accept, alu_fn=101.
- Opcode 0x3E (MVI A) → illegal pulses once, no strobes, instr_ready stays 1. A second instr_valid during the busy window of an ADD is not accepted.
- abort asserted in TMP_MEM → IDLE next cycle, no done, no alu_to_a. The next ADI (0xC6) completes normally.
